uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding a UART transmitter through a three-state
// handshake (IDLE -> LOAD -> BUSY).
//
// Define UART_TXF_OVF_EN to build the sticky overflow flag. Without it,
// ovf_o is tied to 0 and no overflow logic is built.
//
//   state | meaning
//   IDLE  | no frame in progress; pops the FIFO head when not empty
//   LOAD  | byte on t_data_o, tx_en_o high, waiting for a baud tick
//   BUSY  | transmitter owns the byte; waiting for t_done_i
module uart_tx_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     flush_i,
  input  logic                     tx_tick_i,
  input  logic                     t_done_i,
  output logic [7:0]               t_data_o,
  output logic                     tx_en_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop;
  logic           push_ok;

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);

  // A flush discards the whole queue, so it also suppresses a pop that cycle.
  // A pop frees a slot, which lets a push to a full FIFO go through.
  assign push_ok = wr_en_i && !flush_i && (!full_o || pop);

  assign tx_en_o = (state == LOAD);
  assign busy_o  = (state != IDLE) || !empty_o;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and pop decision
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_o && !flush_i) begin
          pop        = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (tx_tick_i) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (t_done_i) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // FIFO storage; no reset needed, validity is tracked by count_o
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (flush_i) begin
      count_o <= '0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  // Output byte register, loaded only on a pop and held through LOAD and BUSY.
  // On a simultaneous push and pop when full, both pointers address the same
  // slot; the read here sees the old head before the write lands.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      t_data_o <= 8'h00;
    end else if (pop) begin
      t_data_o <= mem[rd_ptr];
    end
  end

`ifdef UART_TXF_OVF_EN
  logic drop;

  assign drop = wr_en_i && !flush_i && full_o && !pop;

  // Sticky overflow flag, cleared by flush or reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_o <= 1'b0;
    end else if (flush_i) begin
      ovf_o <= 1'b0;
    end else if (drop) begin
      ovf_o <= 1'b1;
    end
  end
`else
  assign ovf_o = 1'b0;
`endif

endmodule
